// File: rtl/rhd_emu_pkg.sv
// Shared types and constants for the RHD2000 SPI responder emulation: opcodes,
// special command words, state encoding and the read-only register contents.
package rhd_emu_pkg;

    typedef logic [15:0] rhd_word_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } rhd_emu_state_t;

    typedef enum logic [2:0] {
        OP_CONVERT,
        OP_CALIBRATE,
        OP_CLEAR,
        OP_WRITE,
        OP_READ,
        OP_OTHER
    } rhd_emu_op_t;

    // Opcode field c[15:14]; CALIBRATE and CLEAR are single words inside the 01 space.
    localparam logic [1:0] CMD_CONVERT   = 2'b00;
    localparam logic [1:0] CMD_CALIBRATE = 2'b01;
    localparam logic [1:0] CMD_CLEAR     = 2'b01;
    localparam logic [1:0] CMD_WRITE     = 2'b10;
    localparam logic [1:0] CMD_READ      = 2'b11;

    localparam rhd_word_t CALIBRATE_WORD = 16'h5500;
    localparam rhd_word_t CLEAR_WORD     = 16'h6A00;

    localparam int REG_FILE_SIZE = 22;

    localparam logic [7:0] ROM_DIE_REV   = 8'h01;
    localparam logic [7:0] ROM_UNIPOLAR  = 8'h00;

    function automatic rhd_emu_op_t decode_op(input rhd_word_t cmd);
        if (cmd == CALIBRATE_WORD && cmd[15:14] == CMD_CALIBRATE) return OP_CALIBRATE;
        if (cmd == CLEAR_WORD && cmd[15:14] == CMD_CLEAR) return OP_CLEAR;
        case (cmd[15:14])
            CMD_CONVERT: return OP_CONVERT;
            CMD_WRITE:   return OP_WRITE;
            CMD_READ:    return OP_READ;
            default:     return OP_OTHER;
        endcase
    endfunction

    // Read-only address space; register-file addresses are overlaid by the caller.
    function automatic logic [7:0] rom_byte(input logic [5:0] addr,
                                            input logic [7:0] num_amps,
                                            input logic [7:0] chip_id);
        case (addr)
            6'd40:   return 8'h49;
            6'd41:   return 8'h4E;
            6'd42:   return 8'h54;
            6'd43:   return 8'h41;
            6'd44:   return 8'h4E;
            6'd60:   return ROM_DIE_REV;
            6'd61:   return ROM_UNIPOLAR;
            6'd62:   return num_amps;
            6'd63:   return chip_id;
            default: return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/rhd_emu_sync_edge.sv
// Multi-flop synchronizer for one asynchronous input plus rise/fall detection
// on the synchronized level.
module rhd_emu_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Reset to low: a CS still low when reset lifts shows no edge, so a frame
    // only starts after CS has been seen high and falls again.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make each stage take the previous
            // stage's old value, giving a true shift chain.
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/rhd_spi_responder.sv
// RHD2000-family SPI responder: decodes 16-bit commands, holds register file and ROM,
// returns results two frames later on MISO. Define RHD_EMU_RAMP_EN for ramp CONVERT data.
module rhd_spi_responder
    import rhd_emu_pkg::*;
#(
    parameter int CHIP_ID     = 1,
    parameter int NUM_AMPS    = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        CS,
    input  logic        SCLK,
    input  logic        MOSI,
    output logic        MISO,
    output logic        frame_done,
    output logic        frame_err,
    output logic [15:0] last_cmd,
    output logic [31:0] cmd_count
);

    localparam logic [4:0] BITS_FRAME = 5'd16;
    localparam logic [4:0] BITS_SAT   = 5'd17;

    logic cs_level_unused, cs_rise, cs_fall;
    logic sclk_level_unused, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise_unused, mosi_fall_unused;

    rhd_emu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_cs (
        .clk_i  (aclk),
        .rst_n_i(aresetn),
        .d_i    (CS),
        .q_o    (cs_level_unused),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    rhd_emu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk_i  (aclk),
        .rst_n_i(aresetn),
        .d_i    (SCLK),
        .q_o    (sclk_level_unused),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    rhd_emu_sync_edge #(.STAGES(SYNC_STAGES)) u_sync_mosi (
        .clk_i  (aclk),
        .rst_n_i(aresetn),
        .d_i    (MOSI),
        .q_o    (mosi_s),
        .rise_o (mosi_rise_unused),
        .fall_o (mosi_fall_unused)
    );

    rhd_emu_state_t state_q, state_d;
    logic           load_frame, shift_in_en, shift_out_en, commit;

    logic [4:0]  bit_cnt_q;
    rhd_word_t   shift_in_q, shift_out_q;
    rhd_word_t   res1_q, res2_q, last_cmd_q;
    rhd_word_t   result_d, convert_value;
    logic [31:0] cmd_count_q;
    logic [7:0]  regs_q [REG_FILE_SIZE];

    rhd_emu_op_t op;
    logic [5:0]  cmd_addr;
    logic [7:0]  rd_byte;

    assign op       = decode_op(shift_in_q);
    assign cmd_addr = shift_in_q[13:8];

    always_ff @(posedge aclk) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cs_fall) state_d = SHIFT;
            SHIFT:   if (cs_rise) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        // NOTE: every output gets a default before the case, so no path leaves
        // one unassigned and no latch is inferred.
        load_frame   = 1'b0;
        shift_in_en  = 1'b0;
        shift_out_en = 1'b0;
        commit       = 1'b0;
        frame_done   = 1'b0;
        frame_err    = 1'b0;
        case (state_q)
            IDLE:  load_frame = cs_fall;
            SHIFT: begin
                shift_in_en  = sclk_rise;
                shift_out_en = sclk_fall;
            end
            DONE: begin
                commit     = (bit_cnt_q == BITS_FRAME);
                frame_done = (bit_cnt_q == BITS_FRAME);
                frame_err  = (bit_cnt_q != BITS_FRAME);
            end
            default: ;
        endcase
    end

`ifdef RHD_EMU_RAMP_EN
    logic [15:0] ramp_q;

    // Ramp advances after the channel-0 result has been captured into the pipeline.
    always_ff @(posedge aclk) begin
        if (!aresetn)
            ramp_q <= '0;
        else if (commit && op == OP_CONVERT && cmd_addr == 6'd0)
            ramp_q <= ramp_q + 16'd1;
    end

    assign convert_value = ramp_q + {2'b00, cmd_addr, 8'h00};
`else
    assign convert_value = 16'h8000 | {10'd0, cmd_addr};
`endif

    always_comb begin
        rd_byte = rom_byte(cmd_addr, 8'(NUM_AMPS), 8'(CHIP_ID));
        for (int i = 0; i < REG_FILE_SIZE; i++) begin
            if (cmd_addr == 6'(i)) rd_byte = regs_q[i];
        end
        result_d = '0;
        case (op)
            OP_CONVERT: result_d = convert_value;
            OP_WRITE:   result_d = {8'hFF, shift_in_q[7:0]};
            OP_READ:    result_d = {8'h00, rd_byte};
            default:    result_d = '0;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            bit_cnt_q   <= '0;
            shift_in_q  <= '0;
            shift_out_q <= '0;
            res1_q      <= '0;
            res2_q      <= '0;
            last_cmd_q  <= '0;
            cmd_count_q <= '0;
            // NOTE: the register file must read back zero after reset, so every
            // entry is cleared here; this keeps it in flops rather than RAM.
            for (int i = 0; i < REG_FILE_SIZE; i++) regs_q[i] <= '0;
        end else begin
            if (load_frame) begin
                bit_cnt_q   <= '0;
                shift_out_q <= res2_q;
            end
            if (shift_in_en) begin
                shift_in_q <= {shift_in_q[14:0], mosi_s};
                if (bit_cnt_q != BITS_SAT) bit_cnt_q <= bit_cnt_q + 5'd1;
            end
            if (shift_out_en) shift_out_q <= {shift_out_q[14:0], 1'b0};
            if (commit) begin
                res2_q      <= res1_q;
                res1_q      <= result_d;
                last_cmd_q  <= shift_in_q;
                cmd_count_q <= cmd_count_q + 32'd1;
                // Addresses beyond the register file match no entry and are dropped.
                for (int i = 0; i < REG_FILE_SIZE; i++) begin
                    if (op == OP_WRITE && cmd_addr == 6'(i)) regs_q[i] <= shift_in_q[7:0];
                end
            end
        end
    end

    assign MISO      = shift_out_q[15];
    assign last_cmd  = last_cmd_q;
    assign cmd_count = cmd_count_q;

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Self-checking bench for rhd_spi_responder: directed scenarios plus random command
// frames, checked against a frame-level reference model of the RHD chip.
module tb_rhd_spi_responder;

    logic        aclk = 1'b0;
    logic        aresetn, CS, SCLK, MOSI;
    logic        MISO, frame_done, frame_err;
    logic [15:0] last_cmd;
    logic [31:0] cmd_count;

    always #5 aclk = ~aclk;

    rhd_spi_responder dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .CS        (CS),
        .SCLK      (SCLK),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .frame_done(frame_done),
        .frame_err (frame_err),
        .last_cmd  (last_cmd),
        .cmd_count (cmd_count)
    );

    int vectors = 0;
    int errors  = 0;
    int half    = 8;
    int done_seen = 0;
    int err_seen  = 0;

    always @(negedge aclk) begin
        if (frame_done === 1'b1) done_seen++;
        if (frame_err === 1'b1)  err_seen++;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: register file, result history (two leading zeros give the
    // two-frame latency), ramp value, valid-frame count and last command.
    logic [7:0]  m_regs [22];
    logic [15:0] m_hist [$];
    logic [15:0] m_ramp;
    int unsigned m_count;
    logic [15:0] m_last;

    task automatic model_reset();
        for (int i = 0; i < 22; i++) m_regs[i] = 8'h00;
        m_hist  = {16'h0000, 16'h0000};
        m_ramp  = 16'h0000;
        m_count = 0;
        m_last  = 16'h0000;
    endtask

    function automatic logic [7:0] model_read(input int a);
        if (a <= 21) return m_regs[a];
        case (a)
            40: return 8'h49;
            41: return 8'h4E;
            42: return 8'h54;
            43: return 8'h41;
            44: return 8'h4E;
            60: return 8'd1;
            61: return 8'd0;
            62: return 8'd32;
            63: return 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_exec(input logic [15:0] c, output logic [15:0] r);
        int a;
        a = int'(c[13:8]);
        case (c[15:14])
            2'b10: begin
                if (a <= 21) m_regs[a] = c[7:0];
                r = {8'hFF, c[7:0]};
            end
            2'b11: r = {8'h00, model_read(a)};
            2'b00: begin
`ifdef RHD_EMU_RAMP_EN
                r = m_ramp + 16'(a * 256);
                if (a == 0) m_ramp = m_ramp + 16'd1;
`else
                r = 16'h8000 + 16'(a);
`endif
            end
            default: r = 16'h0000;
        endcase
    endtask

    function automatic logic [15:0] rd(input int r);
        return {2'b11, r[5:0], 8'h00};
    endfunction

    function automatic logic [15:0] wr(input int r, input logic [7:0] d);
        return {2'b10, r[5:0], d};
    endfunction

    function automatic logic [15:0] cv(input int ch);
        return {2'b00, ch[5:0], 8'h00};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge aclk);
    endtask

    task automatic bit_xfer(input logic b, output logic m);
        MOSI = b;
        cyc(half);
        m = MISO;
        SCLK = 1'b1;
        cyc(half);
        SCLK = 1'b0;
    endtask

    task automatic frame(input logic [15:0] c, input int nbits, output logic [15:0] mw);
        logic [15:0] sh;
        logic        m;
        sh = c;
        mw = '0;
        CS = 1'b0;
        cyc(half);
        for (int i = 0; i < nbits; i++) begin
            bit_xfer(sh[15], m);
            sh = sh << 1;
            mw = {mw[14:0], m};
        end
        cyc(half);
        CS = 1'b1;
        cyc(8);
    endtask

    task automatic do_frame(input logic [15:0] c, input string tag, output logic [15:0] mw);
        int d0, e0;
        logic [15:0] r, exp;
        d0 = done_seen;
        e0 = err_seen;
        frame(c, 16, mw);
        exp = m_hist.pop_front();
        model_exec(c, r);
        m_hist.push_back(r);
        m_count++;
        m_last = c;
        check({tag, " miso"}, 32'(mw), 32'(exp));
        check({tag, " done pulses"}, 32'(done_seen - d0), 32'd1);
        check({tag, " err pulses"}, 32'(err_seen - e0), 32'd0);
        check({tag, " cmd_count"}, cmd_count, 32'(m_count));
        check({tag, " last_cmd"}, 32'(last_cmd), 32'(m_last));
    endtask

    task automatic err_frame(input logic [15:0] c, input int nbits, input string tag);
        int d0, e0;
        logic [15:0] mw;
        d0 = done_seen;
        e0 = err_seen;
        frame(c, nbits, mw);
        check({tag, " done pulses"}, 32'(done_seen - d0), 32'd0);
        check({tag, " err pulses"}, 32'(err_seen - e0), 32'd1);
        check({tag, " cmd_count"}, cmd_count, 32'(m_count));
    endtask

    task automatic hard_reset();
        aresetn = 1'b0;
        cyc(3);
        aresetn = 1'b1;
        model_reset();
        cyc(4);
    endtask

    task automatic glitch_cs();
        @(negedge aclk);
        #1 CS = ~CS;
        #2 CS = ~CS;
    endtask

    initial begin
        logic [15:0] mw, c;
        logic        m;
        int          k, e0, d0;

        aresetn = 1'b0;
        CS      = 1'b1;
        SCLK    = 1'b0;
        MOSI    = 1'b0;
        model_reset();
        cyc(4);
        check("reset miso", 32'(MISO), 32'd0);
        check("reset frame_done", 32'(frame_done), 32'd0);
        check("reset frame_err", 32'(frame_err), 32'd0);
        check("reset last_cmd", 32'(last_cmd), 32'd0);
        check("reset cmd_count", cmd_count, 32'd0);
        aresetn = 1'b1;
        cyc(4);

        // ROM reads: "INT" arrives two frames after each read.
        do_frame(rd(40), "t1 f1", mw);
        do_frame(rd(41), "t1 f2", mw);
        do_frame(rd(42), "t1 f3", mw);
        check("t1 f3 literal", 32'(mw), 32'h0049);
        do_frame(rd(63), "t1 f4", mw);
        check("t1 f4 literal", 32'(mw), 32'h004E);
        do_frame(rd(63), "t1 f5", mw);
        check("t1 f5 literal", 32'(mw), 32'h0054);
        check("t1 cmd_count literal", cmd_count, 32'd5);

        // Write then read back; write above the register file is dropped.
        hard_reset();
        do_frame(wr(5, 8'hA5), "t2 f1", mw);
        do_frame(rd(5), "t2 f2", mw);
        do_frame(16'h6A00, "t2 f3", mw);
        check("t2 f3 literal", 32'(mw), 32'hFFA5);
        do_frame(16'h6A00, "t2 f4", mw);
        check("t2 f4 literal", 32'(mw), 32'h00A5);
        do_frame(wr(30, 8'h77), "t2 f5", mw);
        do_frame(rd(30), "t2 f6", mw);
        do_frame(16'h5500, "t2 f7", mw);
        check("t2 f7 literal", 32'(mw), 32'hFF77);
        do_frame(16'h6A00, "t2 f8", mw);
        check("t2 f8 literal", 32'(mw), 32'h0000);

        // Conversions on channel 3.
        hard_reset();
`ifdef RHD_EMU_RAMP_EN
        for (int i = 0; i < 4; i++) do_frame(cv(0), "t3 ch0", mw);
`endif
        do_frame(cv(3), "t3 cv a", mw);
        do_frame(cv(3), "t3 cv b", mw);
        do_frame(16'h6A00, "t3 clr a", mw);
`ifdef RHD_EMU_RAMP_EN
        check("t3 conv a literal", 32'(mw), 32'h0304);
`else
        check("t3 conv a literal", 32'(mw), 32'h8003);
`endif
        do_frame(16'h6A00, "t3 clr b", mw);
`ifdef RHD_EMU_RAMP_EN
        check("t3 conv b literal", 32'(mw), 32'h0304);
`else
        check("t3 conv b literal", 32'(mw), 32'h8003);
`endif

        // Short frame between valid frames leaves the pipeline untouched.
        hard_reset();
        do_frame(rd(63), "t4 f1", mw);
        err_frame(rd(62), 10, "t4 short");
        do_frame(rd(62), "t4 f2", mw);
        do_frame(16'h6A00, "t4 f3", mw);
        check("t4 f3 literal", 32'(mw), 32'h0001);
        do_frame(16'h6A00, "t4 f4", mw);
        check("t4 f4 literal", 32'(mw), 32'h0020);
        err_frame(rd(62), 18, "t4 long");

        // Reset in the middle of a frame.
        do_frame(wr(1, 8'hFF), "t5 w1", mw);
        do_frame(wr(2, 8'hFF), "t5 w2", mw);
        e0 = err_seen;
        d0 = done_seen;
        CS = 1'b0;
        cyc(half);
        repeat (7) bit_xfer(1'b1, m);
        check("t5 miso before reset", 32'(MISO), 32'd1);
        aresetn = 1'b0;
        cyc(1);
        check("t5 miso in reset", 32'(MISO), 32'd0);
        check("t5 cmd_count in reset", cmd_count, 32'd0);
        check("t5 last_cmd in reset", 32'(last_cmd), 32'd0);
        cyc(2);
        aresetn = 1'b1;
        CS = 1'b1;
        model_reset();
        cyc(8);
        check("t5 no err after reset", 32'(err_seen - e0), 32'd0);
        check("t5 no done after reset", 32'(done_seen - d0), 32'd0);
        do_frame(rd(63), "t5 f1", mw);
        do_frame(16'h6A00, "t5 f2", mw);
        do_frame(16'h6A00, "t5 f3", mw);
        check("t5 f3 literal", 32'(mw), 32'h0001);

        // Fast SCLK with sub-cycle CS glitches while SCLK idles.
        half = 4;
        e0 = err_seen;
        d0 = done_seen;
        for (int i = 0; i < 4; i++) begin
            glitch_cs();
            glitch_cs();
            do_frame(rd(1 + i), "t6 frame", mw);
        end
        check("t6 done total", 32'(done_seen - d0), 32'd4);
        check("t6 err total", 32'(err_seen - e0), 32'd0);

        // Random command mix against the model.
        for (int n = 0; n < 24; n++) begin
            k = int'($urandom_range(0, 4));
            case (k)
                0:       c = rd(int'($urandom_range(0, 63)));
                1:       c = wr(int'($urandom_range(0, 31)), 8'($urandom));
                2:       c = cv(int'($urandom_range(0, 3))) | 16'($urandom_range(0, 255));
                3:       c = 16'h6A00;
                default: c = 16'($urandom);
            endcase
            do_frame(c, "rand", mw);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
